maxpool_2x2: RTL and testbench
==============================

MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

Interface
REQ-001 Parameter DATA_W, default 32: activation width, two's-complement signed.
REQ-002 Parameter ROW_W, default 8: input row length in pixels; even, >=2.
REQ-003 Parameter ROW_H, default 8: input rows per frame; even, >=2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input pixel present.
REQ-007 in_ready  output  1  block accepts pixel this cycle.
REQ-008 in_data  input  DATA_W  signed pixel, raster order.
REQ-009 out_valid  output  1  pooled value present.
REQ-010 out_ready  input  1  consumer accepts pooled value.
REQ-011 out_data  output  DATA_W  signed 2x2 window maximum.
REQ-012 out_last  output  1  qualifies the final pooled value of a frame.

Function
REQ-013 Transfer occurs when valid and ready are both high on a rising edge, on each side independently.
REQ-014 States: EVEN_ROW, ODD_ROW; start in EVEN_ROW; move to the other state after ROW_W accepted pixels.
REQ-015 EVEN_ROW: pixels at columns 2k and 2k+1 reduce to a signed max, written to line-buffer entry k (ROW_W/2 entries).
REQ-016 ODD_ROW: the signed max of columns 2k, 2k+1 and buffer entry k loads the output register on acceptance of column 2k+1.
REQ-017 Latency: out_valid rises the cycle after the column-2k+1 odd-row pixel is accepted.
REQ-018 Comparison is signed over full DATA_W bits (-1 > -2; 0 > -3); equal values yield that value.
REQ-019 Single output register: in_ready = !out_valid || out_ready; EVEN_ROW pixels and column-2k ODD_ROW pixels obey the same rule.
REQ-020 While out_valid && !out_ready, out_data and out_last hold stable.
REQ-021 A new result loads in the same cycle the previous one is consumed; no bubble.
REQ-022 Column counter wraps 0..ROW_W-1; row counter wraps 0..ROW_H-1; after row ROW_H-1 the next pixel begins a new frame in EVEN_ROW.
REQ-023 out_last is high with the value from row ROW_H-1, column ROW_W-1.
REQ-024 Output rate: (ROW_W/2)*(ROW_H/2) values per frame.

Reset
REQ-025 rst (sampled at a clock edge) forces out_valid=0, out_data=0, out_last=0, state=EVEN_ROW, counters=0.
REQ-026 Reset mid-frame discards partial rows and any unconsumed output; the next accepted pixel is row 0, column 0.
REQ-027 Line-buffer contents are not reset; they are always written before being read.
REQ-028 in_ready is 1 in the cycle after reset deasserts.

Configuration
REQ-029 Macro MAXPOOL_RELU_EN: when defined, out_data = max(window, 0) (fused ReLU).
REQ-030 Without MAXPOOL_RELU_EN, out_data is the unclamped signed window maximum.
REQ-031 The macro does not change timing, handshake, or port list.

Structure
REQ-032 Shared package cnn_pkg holds DATA_W default, act_t (signed DATA_W), and the row-state enum.
REQ-033 Sub-module max2: combinational signed two-input max, instantiated for the horizontal and vertical reductions.

Verification
REQ-034 ROW_W=4, ROW_H=2; rows [1,5,-3,2],[4,0,7,-8], out_ready=1 -> out 5 then 7 (out_last=1 on 7).
REQ-035 All-negative window [-1,-2],[-5,-9] -> -1 without MAXPOOL_RELU_EN; 0 with it.
REQ-036 Hold out_ready=0 for 5 cycles after first result -> out_data stable, in_ready=0, no pixel lost; release -> sequence continues.
REQ-037 Pulse rst during row 1, then stream a full frame [2,2,2,2],[3,3,3,3] -> out 3,3 only; no stale value.
REQ-038 Two back-to-back frames with continuous in_valid, out_ready=1 -> exactly 2 outputs per frame; out_last once per frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling blocks.
//   DATA_W_DEF  : default activation width
//   act_t       : signed activation at the default width
//   row_state_e : which row of a 2x2 window pair is being streamed
//   idx_w()     : counter/index width helper that never returns 0
package cnn_pkg;

  localparam int DATA_W_DEF = 32;

  typedef logic signed [DATA_W_DEF-1:0] act_t;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_state_e;

  // Width needed to count 0..n-1; a one-entry range still gets one bit so
  // no vector ends up zero-width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_2x2_if.sv
// Stream bundle for maxpool_2x2: pixel input side and pooled output side.
//   in_valid/in_ready/in_data              : raster-order pixel stream
//   out_valid/out_ready/out_data/out_last  : pooled stream, last marks frame end
// Modports:
//   slave  : the pooling block
//   master : the environment feeding pixels and consuming results
interface maxpool_2x2_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/maxpool_2x2_max2.sv
// max2: combinational signed two-input maximum.
//   a, b : signed operands
//   y    : the larger of a and b (either one when equal)
module max2 #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  assign y = (a > b) ? a : b;

endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 / stride-2 signed max pooling.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : maxpool_2x2_if.slave (pixel in, pooled value out)
// Parameters: DATA_W (activation width), ROW_W / ROW_H (frame size, even).
// Optional feature: define MAXPOOL_RELU_EN to clamp results at zero (fused
// ReLU); timing and handshake are identical either way.
//
// Even rows reduce each horizontal pixel pair into a line-buffer entry; odd
// rows reduce their pair, combine it with that entry and load the single
// output register. in_ready follows the output register only, so a stalled
// result blocks every input pixel until it is taken.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROW_W  = 8,
  parameter int ROW_H  = 8
) (
  input  logic          clk,
  input  logic          rst,
  maxpool_2x2_if.slave  bus
);

  localparam int HALF_W = ROW_W / 2;
  localparam int COL_W  = idx_w(ROW_W);
  localparam int ROW_CW = idx_w(ROW_H);
  localparam int IDX_W  = idx_w(HALF_W);

  row_state_e               state_reg, state_next;
  logic [COL_W-1:0]         col_reg, col_next;
  logic [ROW_CW-1:0]        row_reg, row_next;
  logic                     out_valid_reg, out_valid_next;
  logic                     out_last_reg, out_last_next;
  logic signed [DATA_W-1:0] out_data_reg, out_data_next;

  // Column-2k pixel of the current row, waiting for its partner.
  logic signed [DATA_W-1:0] hold_reg;
  // Registered line-buffer read, issued on the odd-row column-2k pixel so it
  // is ready when column 2k+1 arrives, however long that takes.
  logic signed [DATA_W-1:0] lb_rd_reg;
  logic signed [DATA_W-1:0] line_buf [HALF_W];

  logic                     in_ready;
  logic                     in_fire;
  logic                     out_fire;
  logic                     col_last;
  logic                     row_last;
  logic                     odd_col;
  logic [IDX_W-1:0]         pair_idx;
  logic signed [DATA_W-1:0] h_max;
  logic signed [DATA_W-1:0] v_max;
  logic signed [DATA_W-1:0] pooled;

  assign in_ready      = !out_valid_reg || bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;

  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_reg && bus.out_ready;
  assign col_last = (col_reg == COL_W'(ROW_W - 1));
  assign row_last = (row_reg == ROW_CW'(ROW_H - 1));
  assign odd_col  = col_reg[0];
  assign pair_idx = IDX_W'(col_reg >> 1);

  // Horizontal pair reduction, then vertical against the buffered even row.
  max2 #(.DATA_W(DATA_W)) u_hmax (
    .a (hold_reg),
    .b (bus.in_data),
    .y (h_max)
  );

  max2 #(.DATA_W(DATA_W)) u_vmax (
    .a (h_max),
    .b (lb_rd_reg),
    .y (v_max)
  );

`ifdef MAXPOOL_RELU_EN
  assign pooled = v_max[DATA_W-1] ? '0 : v_max;
`else
  assign pooled = v_max;
`endif

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;

    if (out_fire) begin
      out_valid_next = 1'b0;
    end

    if (in_fire) begin
      if (col_last) begin
        col_next = '0;
        if (row_last) begin
          row_next   = '0;
          state_next = EVEN_ROW;
        end else begin
          row_next   = row_reg + ROW_CW'(1);
          state_next = (state_reg == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end
      end else begin
        col_next = col_reg + COL_W'(1);
      end

      // Overrides the clear above when a result is consumed and replaced in
      // the same cycle, so back-to-back results need no bubble.
      if (state_reg == ODD_ROW && odd_col) begin
        out_valid_next = 1'b1;
        out_data_next  = pooled;
        out_last_next  = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EVEN_ROW;
      col_reg       <= '0;
      row_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      hold_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      if (in_fire && !odd_col) begin
        hold_reg <= bus.in_data;
      end
    end
  end

  // Line buffer has no reset: every entry is written in an even row before
  // the following odd row reads it, including after a mid-frame reset.
  always_ff @(posedge clk) begin
    if (in_fire && state_reg == EVEN_ROW && odd_col) begin
      line_buf[pair_idx] <= h_max;
    end
    if (in_fire && state_reg == ODD_ROW && !odd_col) begin
      lb_rd_reg <= line_buf[pair_idx];
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
`timescale 1ns/1ps
module tb_maxpool_2x2;
  import cnn_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int RH = 2;
  localparam int NPIX = RW * RH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  act_t out_dq[$];
  logic out_lq[$];

  maxpool_2x2_if #(.DATA_W(DW)) bus ();

  maxpool_2x2 #(
    .DATA_W (DW),
    .ROW_W  (RW),
    .ROW_H  (RH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Handshake signals are stable from posedge+1 to the next posedge, so a
  // transfer seen here completes on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      out_dq.push_back(bus.out_data);
      out_lq.push_back(bus.out_last);
      $display("[%0t] out data=%0d last=%0b", $time, bus.out_data, bus.out_last);
    end
    if (!rst && bus.in_valid && bus.in_ready) begin
      acc_cnt++;
      $display("[%0t] in  data=%0d", $time, bus.in_data);
    end
  end

  function automatic act_t exp_out(input act_t v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? act_t'(0) : v;
`else
    return v;
`endif
  endfunction

  // Present one pixel and return just after the edge that accepts it.
  task automatic send_pixel(input act_t v, output int stalls);
    int waited;
    waited = 0;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, required 1", bus.in_ready, waited);
        bus.in_valid = 1'b0;
        stalls = waited;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    stalls = waited;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    out_dq.delete();
    out_lq.delete();
    acc_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== act_t'(0)) begin errors++; $display("FAIL reset_out_data: got %0d required 0", bus.out_data); end
    checks++;
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", bus.out_last); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    act_t f[NPIX];
    act_t exp_d[2];
    logic exp_l[2];
    act_t got_d;
    logic got_l;
    int   s;
    f     = '{1, 5, -3, 2, 4, 0, 7, -8};
    exp_d = '{5, 7};
    exp_l = '{1'b0, 1'b1};
    clear_obs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(f[i], s);
      if (i == 4) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", bus.out_valid); end
      end
      if (i == 5) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b required 1", bus.out_valid); end
        checks++;
        if (bus.out_data !== act_t'(5)) begin errors++; $display("FAIL basic_latency_data: got %0d required 5", bus.out_data); end
      end
    end
    drain();
    checks++;
    if (out_dq.size() != 2) begin errors++; $display("FAIL basic_count: got %0d required 2", out_dq.size()); end
    for (int i = 0; i < 2; i++) begin
      got_d = (i < out_dq.size()) ? out_dq[i] : 'x;
      got_l = (i < out_lq.size()) ? out_lq[i] : 1'bx;
      checks++;
      if (got_d !== exp_d[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d required %0d", i, got_d, exp_d[i]); end
      checks++;
      if (got_l !== exp_l[i]) begin errors++; $display("FAIL basic_last[%0d]: got %b required %b", i, got_l, exp_l[i]); end
    end
  endtask

  task automatic test_negative();
    act_t f[NPIX];
    act_t exp_d[2];
    act_t got_d;
    int   s;
    f     = '{-1, -2, -7, -7, -5, -9, -3, -4};
    exp_d = '{exp_out(-1), exp_out(-3)};
    clear_obs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) send_pixel(f[i], s);
    drain();
    checks++;
    if (out_dq.size() != 2) begin errors++; $display("FAIL neg_count: got %0d required 2", out_dq.size()); end
    for (int i = 0; i < 2; i++) begin
      got_d = (i < out_dq.size()) ? out_dq[i] : 'x;
      checks++;
      if (got_d !== exp_d[i]) begin errors++; $display("FAIL neg_data[%0d]: got %0d required %0d", i, got_d, exp_d[i]); end
    end
  endtask

  task automatic test_stall();
    act_t f[NPIX];
    act_t exp_d[2];
    logic exp_l[2];
    act_t got_d;
    logic got_l;
    int   s;
    f     = '{1, 5, -3, 2, 4, 0, 7, -8};
    exp_d = '{5, 7};
    exp_l = '{1'b0, 1'b1};
    clear_obs();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(f[i], s);
    // Next pixel is offered while the first result is held back.
    bus.in_valid = 1'b1;
    bus.in_data  = f[6];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b required 1", c, bus.out_valid); end
      checks++;
      if (bus.out_data !== act_t'(5)) begin errors++; $display("FAIL stall_data[%0d]: got %0d required 5", c, bus.out_data); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b required 0", c, bus.in_ready); end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_pixel(f[6], s);
    send_pixel(f[7], s);
    drain();
    checks++;
    if (acc_cnt != NPIX) begin errors++; $display("FAIL stall_accepted: got %0d required %0d", acc_cnt, NPIX); end
    checks++;
    if (out_dq.size() != 2) begin errors++; $display("FAIL stall_count: got %0d required 2", out_dq.size()); end
    for (int i = 0; i < 2; i++) begin
      got_d = (i < out_dq.size()) ? out_dq[i] : 'x;
      got_l = (i < out_lq.size()) ? out_lq[i] : 1'bx;
      checks++;
      if (got_d !== exp_d[i]) begin errors++; $display("FAIL stall_data_out[%0d]: got %0d required %0d", i, got_d, exp_d[i]); end
      checks++;
      if (got_l !== exp_l[i]) begin errors++; $display("FAIL stall_last[%0d]: got %b required %b", i, got_l, exp_l[i]); end
    end
  endtask

  task automatic test_reset_mid();
    act_t f[NPIX];
    act_t got_d;
    logic got_l;
    logic exp_l[2];
    int   s;
    exp_l = '{1'b0, 1'b1};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(act_t'(9), s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk);
    #1;
    clear_obs();
    bus.out_ready = 1'b1;
    f = '{2, 2, 2, 2, 3, 3, 3, 3};
    for (int i = 0; i < NPIX; i++) send_pixel(f[i], s);
    drain();
    checks++;
    if (out_dq.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d required 2", out_dq.size()); end
    for (int i = 0; i < 2; i++) begin
      got_d = (i < out_dq.size()) ? out_dq[i] : 'x;
      got_l = (i < out_lq.size()) ? out_lq[i] : 1'bx;
      checks++;
      if (got_d !== act_t'(3)) begin errors++; $display("FAIL rstmid_data[%0d]: got %0d required 3", i, got_d); end
      checks++;
      if (got_l !== exp_l[i]) begin errors++; $display("FAIL rstmid_last[%0d]: got %b required %b", i, got_l, exp_l[i]); end
    end
  endtask

  task automatic test_back_to_back();
    act_t f[2*NPIX];
    act_t exp_d[4];
    logic exp_l[4];
    act_t got_d;
    logic got_l;
    int   s;
    int   total_stalls;
    int   last_cnt;
    f     = '{1, 2, 3, 4, 5, 6, 7, 8, -1, -2, -3, -4, 10, -20, 0, -30};
    exp_d = '{6, 8, 10, 0};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_obs();
    bus.out_ready = 1'b1;
    total_stalls = 0;
    for (int i = 0; i < 2*NPIX; i++) begin
      send_pixel(f[i], s);
      total_stalls += s;
    end
    drain();
    checks++;
    if (total_stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d required 0", total_stalls); end
    checks++;
    if (acc_cnt != 2*NPIX) begin errors++; $display("FAIL b2b_accepted: got %0d required %0d", acc_cnt, 2*NPIX); end
    checks++;
    if (out_dq.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d required 4", out_dq.size()); end
    last_cnt = 0;
    for (int i = 0; i < out_lq.size(); i++) if (out_lq[i] === 1'b1) last_cnt++;
    checks++;
    if (last_cnt != 2) begin errors++; $display("FAIL b2b_last_count: got %0d required 2", last_cnt); end
    for (int i = 0; i < 4; i++) begin
      got_d = (i < out_dq.size()) ? out_dq[i] : 'x;
      got_l = (i < out_lq.size()) ? out_lq[i] : 1'bx;
      checks++;
      if (got_d !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d required %0d", i, got_d, exp_d[i]); end
      checks++;
      if (got_l !== exp_l[i]) begin errors++; $display("FAIL b2b_last[%0d]: got %b required %b", i, got_l, exp_l[i]); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
